// File: rtl/mmcam_match_unit.sv
// ============================================================================
// Module   : mmcam_match_unit
// Purpose  : Matching-memory CAM stage. Holds ENTRIES tag entries and, for
//            each incoming packet, decides bypass / match (read partner from
//            MMRAM, optionally freeing it) / store (write operand to MMRAM).
//            Drives the WR_E/RD_E/DEL/ADDR command toward the MMRAM stage
//            together with a registered copy of the packet.
// Ports    : CP          clock, rising edge
//            MR          master reset, asynchronous, active-high
//            Send_in     upstream packet valid
//            Ack_out     upstream ready
//            PACKET_IN   incoming packet {MF, STK, payload, tag}
//            Send_out    downstream packet valid
//            Ack_in      downstream ready
//            PACKET_OUT  registered packet
//            WR_E        MMRAM write enable (operand stored)
//            RD_E        MMRAM read enable (partner fetched)
//            DEL         partner entry freed by this packet
//            ADDR        MMRAM entry address
//            FULL        all entries valid
//            OCC         count of valid entries (MMCAM_OCC_CNT_EN only)
// Options  : MMCAM_OCC_CNT_EN - adds the OCC occupancy counter output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmcam_match_unit #(
  parameter int ENTRIES = 64,
  parameter int ADDR_W  = 6,
  parameter int TAG_W   = 19,
  parameter int PKT_W   = 64
) (
  input  logic              CP,
  input  logic              MR,
  input  logic              Send_in,
  output logic              Ack_out,
  input  logic [PKT_W-1:0]  PACKET_IN,
  output logic              Send_out,
  input  logic              Ack_in,
  output logic [PKT_W-1:0]  PACKET_OUT,
  output logic              WR_E,
  output logic              RD_E,
  output logic              DEL,
  output logic [ADDR_W-1:0] ADDR,
  output logic              FULL
`ifdef MMCAM_OCC_CNT_EN
  ,
  output logic [ADDR_W:0]   OCC
`endif
);

  localparam int KEY_W = TAG_W - 1;

  // Entry table. VALID/STK carry the reset; KEY/LR are only meaningful
  // while VALID is set, so they need no reset.
  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_stk;
  logic [ENTRIES-1:0] r_lr;
  logic [KEY_W-1:0]   r_key [ENTRIES];

  // Registered output stage
  logic              r_send_out;
  logic [PKT_W-1:0]  r_packet_out;
  logic              r_wr_e;
  logic              r_rd_e;
  logic              r_del;
  logic [ADDR_W-1:0] r_addr;

  // Incoming packet fields
  logic              w_mf;
  logic              w_stk_in;
  logic [KEY_W-1:0]  w_key;
  logic              w_lr;

  logic              w_hit;
  logic [ADDR_W-1:0] w_hit_idx;
  logic              w_hit_stk;
  logic [ADDR_W-1:0] w_free_idx;
  logic              w_full;
  logic              w_stall;
  logic              w_ack_out;
  logic              w_accept;
  logic              w_store;
  logic              w_consume;

  assign w_mf     = PACKET_IN[PKT_W-1];
  assign w_stk_in = PACKET_IN[PKT_W-2];
  assign w_key    = PACKET_IN[TAG_W-1:1];
  assign w_lr     = PACKET_IN[0];

  // Priority search: scanning downward means the last assignment made is
  // the lowest matching index, which is the one selected.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_key[i] == w_key) && (r_lr[i] != w_lr)) begin
        w_hit     = 1'b1;
        w_hit_idx = ADDR_W'(i);
      end
      if (!r_valid[i]) begin
        w_free_idx = ADDR_W'(i);
      end
    end
  end

  assign w_hit_stk = r_stk[w_hit_idx];
  assign w_full    = &r_valid;

  // A matching-flag packet that misses in a full table has nowhere to go;
  // hits and bypass packets are never held back by FULL.
  assign w_stall   = w_mf & ~w_hit & w_full;
  assign w_ack_out = (~r_send_out | Ack_in) & ~w_stall;
  assign w_accept  = Send_in & w_ack_out;
  assign w_store   = w_accept & w_mf & ~w_hit;
  assign w_consume = w_accept & w_mf & w_hit & ~w_hit_stk;

  // Table state: the update lands on the accept edge, so the following
  // packet already sees it without any forwarding path.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      r_valid <= '0;
      r_stk   <= '0;
    end else if (w_store) begin
      r_valid[w_free_idx] <= 1'b1;
      r_stk[w_free_idx]   <= w_stk_in;
    end else if (w_consume) begin
      r_valid[w_hit_idx]  <= 1'b0;
    end
  end

  always_ff @(posedge CP) begin
    if (w_store) begin
      r_key[w_free_idx] <= w_key;
      r_lr[w_free_idx]  <= w_lr;
    end
  end

  // Output stage: loaded on accept, held while downstream stalls, command
  // cleared once the packet leaves with nothing new behind it.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      r_send_out   <= 1'b0;
      r_packet_out <= '0;
      r_wr_e       <= 1'b0;
      r_rd_e       <= 1'b0;
      r_del        <= 1'b0;
      r_addr       <= '0;
    end else if (w_accept) begin
      r_send_out   <= 1'b1;
      r_packet_out <= PACKET_IN;
      r_wr_e       <= w_mf & ~w_hit;
      r_rd_e       <= w_mf & w_hit;
      r_del        <= w_mf & w_hit & ~w_hit_stk;
      if (!w_mf) begin
        r_addr <= '0;
      end else if (w_hit) begin
        r_addr <= w_hit_idx;
      end else begin
        r_addr <= w_free_idx;
      end
    end else if (r_send_out && Ack_in) begin
      r_send_out <= 1'b0;
      r_wr_e     <= 1'b0;
      r_rd_e     <= 1'b0;
      r_del      <= 1'b0;
      r_addr     <= '0;
    end
  end

`ifdef MMCAM_OCC_CNT_EN
  localparam logic [ADDR_W:0] C_OCC_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // Tracks popcount(r_valid): moves on exactly the events that set or
  // clear a VALID bit.
  logic [ADDR_W:0] r_occ;

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      r_occ <= '0;
    end else if (w_store) begin
      r_occ <= r_occ + C_OCC_ONE;
    end else if (w_consume) begin
      r_occ <= r_occ - C_OCC_ONE;
    end
  end

  assign OCC = r_occ;
`endif

  assign Ack_out    = w_ack_out;
  assign Send_out   = r_send_out;
  assign PACKET_OUT = r_packet_out;
  assign WR_E       = r_wr_e;
  assign RD_E       = r_rd_e;
  assign DEL        = r_del;
  assign ADDR       = r_addr;
  assign FULL       = w_full;

endmodule

`default_nettype wire

// File: tb/tb_mmcam_match_unit.sv
// ============================================================================
// Module   : tb_mmcam_match_unit
// Purpose  : Self-checking bench for mmcam_match_unit (ENTRIES=4). A small
//            table model predicts every output each cycle; directed
//            sequences add literal expectations, then random traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmcam_match_unit;

  localparam int ENTRIES = 4;
  localparam int ADDR_W  = 2;
  localparam int TAG_W   = 19;
  localparam int PKT_W   = 64;

  logic              CP = 1'b0;
  logic              MR = 1'b0;
  logic              Send_in = 1'b0;
  logic              Ack_out;
  logic [PKT_W-1:0]  PACKET_IN = '0;
  logic              Send_out;
  logic              Ack_in = 1'b1;
  logic [PKT_W-1:0]  PACKET_OUT;
  logic              WR_E;
  logic              RD_E;
  logic              DEL;
  logic [ADDR_W-1:0] ADDR;
  logic              FULL;
`ifdef MMCAM_OCC_CNT_EN
  logic [ADDR_W:0]   OCC;
`endif

  mmcam_match_unit #(
    .ENTRIES (ENTRIES),
    .ADDR_W  (ADDR_W),
    .TAG_W   (TAG_W),
    .PKT_W   (PKT_W)
  ) dut (
    .CP         (CP),
    .MR         (MR),
    .Send_in    (Send_in),
    .Ack_out    (Ack_out),
    .PACKET_IN  (PACKET_IN),
    .Send_out   (Send_out),
    .Ack_in     (Ack_in),
    .PACKET_OUT (PACKET_OUT),
    .WR_E       (WR_E),
    .RD_E       (RD_E),
    .DEL        (DEL),
    .ADDR       (ADDR),
    .FULL       (FULL)
`ifdef MMCAM_OCC_CNT_EN
    ,
    .OCC        (OCC)
`endif
  );

  always #5 CP = ~CP;

  int checks = 0;
  int errors = 0;

  // Reference model: the set of stored operands and the expected output
  // register contents.
  bit          m_valid [ENTRIES];
  bit          m_stk   [ENTRIES];
  logic [17:0] m_key   [ENTRIES];
  bit          m_lr    [ENTRIES];
  bit          e_send;
  logic [63:0] e_pkt;
  bit          e_wr, e_rd, e_del;
  int          e_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input bit mf, input bit stk, input logic [17:0] key,
                                     input bit lr, input logic [42:0] pl);
    return {mf, stk, pl, key, lr};
  endfunction

  function automatic int find_hit(input logic [63:0] p);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_key[i] == p[18:1] && m_lr[i] != p[0]) return i;
    return -1;
  endfunction

  function automatic int find_free();
    for (int i = 0; i < ENTRIES; i++)
      if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int occupancy();
    int n = 0;
    for (int i = 0; i < ENTRIES; i++) n += m_valid[i] ? 1 : 0;
    return n;
  endfunction

  function automatic bit model_full();
    return occupancy() == ENTRIES;
  endfunction

  function automatic bit model_ack();
    bit stall;
    stall = PACKET_IN[63] && (find_hit(PACKET_IN) < 0) && model_full();
    return (!e_send || Ack_in) && !stall;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_stk[i]   = 0;
    end
    e_send = 0; e_pkt = '0; e_wr = 0; e_rd = 0; e_del = 0; e_addr = 0;
  endtask

  // One clock: check the combinational outputs for the current inputs,
  // advance the model across the edge, then check the registered outputs.
  task automatic step(output bit acc);
    bit ea;
    int h, f;
    #1;
    ea = model_ack();
    chk("ack_out", Ack_out, ea);
    chk("full", FULL, model_full());
    acc = Send_in && ea;
    @(posedge CP);
    if (acc) begin
      e_send = 1; e_pkt = PACKET_IN;
      e_wr = 0; e_rd = 0; e_del = 0; e_addr = 0;
      if (PACKET_IN[63]) begin
        h = find_hit(PACKET_IN);
        if (h >= 0) begin
          e_rd = 1; e_addr = h;
          if (!m_stk[h]) begin
            e_del = 1;
            m_valid[h] = 0;
          end
        end else begin
          f = find_free();
          e_wr = 1; e_addr = f;
          m_valid[f] = 1; m_stk[f] = PACKET_IN[62];
          m_key[f] = PACKET_IN[18:1]; m_lr[f] = PACKET_IN[0];
        end
      end
    end else if (e_send && Ack_in) begin
      e_send = 0; e_wr = 0; e_rd = 0; e_del = 0; e_addr = 0;
    end
    #1;
    chk("send_out", Send_out, e_send);
    if (e_send) begin
      chk("packet_out", PACKET_OUT, e_pkt);
      chk("wr_e", WR_E, e_wr);
      chk("rd_e", RD_E, e_rd);
      chk("del", DEL, e_del);
      chk("addr", ADDR, e_addr);
    end
`ifdef MMCAM_OCC_CNT_EN
    chk("occ", OCC, occupancy());
`endif
  endtask

  task automatic send(input logic [63:0] p);
    bit a;
    Send_in = 1; PACKET_IN = p;
    step(a);
    Send_in = 0;
  endtask

  task automatic idle(input int n);
    bit a;
    Send_in = 0;
    for (int i = 0; i < n; i++) step(a);
  endtask

  // Asynchronous reset applied between edges; its effect must be immediate.
  task automatic apply_reset();
    MR = 1;
    #1;
    model_clear();
    chk("rst_send_out", Send_out, 0);
    chk("rst_full", FULL, 0);
    chk("rst_addr", ADDR, 0);
    chk("rst_wr_e", WR_E, 0);
`ifdef MMCAM_OCC_CNT_EN
    chk("rst_occ", OCC, 0);
`endif
    @(negedge CP);
    MR = 0;
  endtask

  logic [63:0] saved;
  bit          pending;
  bit          acc;
  int          stalled;

  initial begin
    model_clear();
    Ack_in = 1;
    @(negedge CP);
    apply_reset();
    chk("rst_packet_out", PACKET_OUT, 0);

    // Store then match then store again in the freed slot
    send(mk(1, 0, 18'h1234, 0, 43'h1));
    chk("t1_wr", WR_E, 1); chk("t1_addr", ADDR, 0); chk("t1_full", FULL, 0);
    send(mk(1, 0, 18'h1234, 1, 43'h2));
    chk("t2_rd", RD_E, 1); chk("t2_del", DEL, 1); chk("t2_addr", ADDR, 0);
    send(mk(1, 0, 18'h1234, 1, 43'h3));
    chk("t3_wr", WR_E, 1); chk("t3_rd", RD_E, 0); chk("t3_addr", ADDR, 0);

    // Bypass
    saved = mk(0, 0, 18'h0777, 1, 43'h5A5A5);
    send(saved);
    chk("byp_pkt", PACKET_OUT, saved);
    chk("byp_wr", WR_E, 0); chk("byp_rd", RD_E, 0); chk("byp_del", DEL, 0);
    idle(2);

    // Sticky entry serves repeated partners
    apply_reset();
    send(mk(1, 1, 18'h0055, 0, 43'h0));
    chk("stk_wr", WR_E, 1); chk("stk_addr", ADDR, 0);
    for (int k = 0; k < 3; k++) begin
      send(mk(1, 0, 18'h0055, 1, 43'(k)));
      chk("stk_rd", RD_E, 1); chk("stk_del", DEL, 0); chk("stk_hit_addr", ADDR, 0);
`ifdef MMCAM_OCC_CNT_EN
      chk("stk_occ", OCC, 1);
`endif
    end
    idle(1);

    // Full stall, then a hitting packet still goes through
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      send(mk(1, 0, 18'(k + 1), 0, 43'h0));
      chk("fill_addr", ADDR, k);
    end
    idle(1);
    chk("fill_full", FULL, 1);
    Send_in = 1; PACKET_IN = mk(1, 0, 18'h0009, 0, 43'h0);
    for (int k = 0; k < 10; k++) begin
      step(acc);
      chk("stall_ack", Ack_out, 0);
    end
    send(mk(1, 0, 18'h0003, 1, 43'h0));
    chk("full_hit_del", DEL, 1); chk("full_hit_addr", ADDR, 2);
    chk("full_cleared", FULL, 0);
    idle(1);

    // Downstream backpressure
    apply_reset();
    Ack_in = 0;
    saved = mk(1, 0, 18'h0100, 0, 43'h77);
    send(saved);
    Send_in = 1; PACKET_IN = mk(1, 0, 18'h0200, 0, 43'h88);
    for (int k = 0; k < 5; k++) begin
      step(acc);
      chk("bp_pkt", PACKET_OUT, saved); chk("bp_addr", ADDR, 0);
      chk("bp_wr", WR_E, 1); chk("bp_ack", Ack_out, 0);
    end
    Ack_in = 1;
    step(acc);
    chk("bp_release_addr", ADDR, 1);
    idle(2);

    // Reset in mid-operation with a packet held downstream
    apply_reset();
    send(mk(1, 0, 18'h0011, 0, 43'h0));
    send(mk(1, 0, 18'h0012, 0, 43'h0));
    Ack_in = 0;
    send(mk(1, 0, 18'h0013, 0, 43'h0));
    idle(1);
    chk("pre_rst_send", Send_out, 1);
    apply_reset();
    Ack_in = 1;
    send(mk(1, 0, 18'h0014, 1, 43'h0));
    chk("post_rst_addr", ADDR, 0); chk("post_rst_wr", WR_E, 1);
    idle(1);

    // Random traffic; packets are held upstream until accepted
    pending = 0;
    stalled = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!pending && ($urandom % 4 != 0)) begin
        pending = 1;
        PACKET_IN = mk($urandom % 5 != 0, $urandom % 6 == 0, 18'($urandom % 6),
                       1'($urandom), {11'($urandom), 32'($urandom)});
      end
      Send_in = pending;
      Ack_in  = ($urandom % 4 != 0);
      step(acc);
      if (acc) begin
        pending = 0;
        stalled = 0;
      end else if (pending) begin
        stalled++;
      end
      if (stalled > 30) begin
        Send_in = 0;
        pending = 0;
        stalled = 0;
        apply_reset();
      end
    end
    Send_in = 0;
    Ack_in  = 1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
